servisia_sram_scoreboard: RTL and testbench

Synthesisable-style, parametrised SRAM bus scoreboard for servisia benches. It passively observes the SRAM read/write bus between the core and the memory model, keeps a shadow copy of written data, and checks every returned read against it after a configurable read latency. Results are exported as a sticky error flag, saturating counters and a first-mismatch capture. It replaces ad-hoc per-cycle reference-RAM comparisons in the bench.

---
 rtl/servisia_scb_pkg.sv | 32 +++
 rtl/servisia_scb_shadow.sv | 43 ++++
 rtl/servisia_sram_scoreboard.sv | 170 +++++++++++++++++
 tb/tb_servisia_sram_scoreboard.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/servisia_scb_pkg.sv
// Shared types and helpers for the SRAM bus scoreboard.
// Latency: n/a (types/functions only).
// Backpressure: n/a.
package servisia_scb_pkg;

    // Pipeline entries are sized for the widest supported bus; instances narrow on use.
    localparam int SCB_MAX_ADDR_WIDTH = 32;
    localparam int SCB_MAX_DATA_WIDTH = 32;
    localparam int SCB_MAX_CNT_WIDTH  = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef struct packed {
        logic                          valid;
        logic [SCB_MAX_ADDR_WIDTH-1:0] addr;
        logic [SCB_MAX_DATA_WIDTH-1:0] exp;
    } rd_entry_t;

    // Increment v, holding at the all-ones value of a width-bit counter.
    function automatic logic [SCB_MAX_CNT_WIDTH-1:0] sat_inc(
        input logic [SCB_MAX_CNT_WIDTH-1:0] v,
        input int unsigned                  width
    );
        logic [SCB_MAX_CNT_WIDTH-1:0] lim;
        lim = {SCB_MAX_CNT_WIDTH{1'b1}} >> (SCB_MAX_CNT_WIDTH - width);
        return (v == lim) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/servisia_scb_shadow.sv
// Shadow copy of tracked SRAM words plus a per-word written flag.
// Latency: combinational read, writes and clears land at the clock edge.
// Backpressure: none; the sweep clears one valid bit per cycle, reset does not touch the array.
module servisia_scb_shadow #(
    parameter int IDX_WIDTH  = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic [IDX_WIDTH-1:0]  widx,
    input  logic [DATA_WIDTH-1:0] wdat,
    input  logic [IDX_WIDTH-1:0]  ridx,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  clr_en,
    input  logic [IDX_WIDTH-1:0]  clr_idx
);

    localparam int DEPTH = 1 << IDX_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid_bits;

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[widx] <= wdat;
        end
    end

    // Writer and sweeper are never active together, so ordering here is moot.
    always_ff @(posedge clk) begin
        if (wen) begin
            valid_bits[widx] <= 1'b1;
        end
        if (clr_en) begin
            valid_bits[clr_idx] <= 1'b0;
        end
    end

    assign rvalid = valid_bits[ridx];
    assign rdata  = mem[ridx];

endmodule

// File: rtl/servisia_sram_scoreboard.sv
// Passive SRAM bus checker: shadows writes, compares reads after RD_LATENCY cycles.
// Latency: compare result visible RD_LATENCY edges after the read issue edge.
// Backpressure: none; observes only, accepts a read every cycle. CNT_WIDTH up to 32.
module servisia_sram_scoreboard
    import servisia_scb_pkg::*;
#(
    parameter int ADDR_WIDTH       = 21,
    parameter int DATA_WIDTH       = 8,
    parameter int TRACK_ADDR_WIDTH = 12,
    parameter int RD_LATENCY       = 1,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  wen_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  ren_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  ready_o,
    output logic                  err_o,
    output logic                  viol_o,
    output logic [CNT_WIDTH-1:0]  check_cnt_o,
    output logic [CNT_WIDTH-1:0]  mismatch_cnt_o,
    output logic                  first_valid_o,
    output logic [ADDR_WIDTH-1:0] first_addr_o,
    output logic [DATA_WIDTH-1:0] first_exp_o,
    output logic [DATA_WIDTH-1:0] first_got_o
);

    localparam logic [TRACK_ADDR_WIDTH-1:0] LAST_IDX = '1;

    state_e                      state;
    logic [TRACK_ADDR_WIDTH-1:0] sweep_idx;
    logic                        running;
    logic                        sweep_en;
    logic                        w_tracked;
    logic                        r_tracked;
    logic                        shadow_we;
    logic                        sh_valid;
    logic [DATA_WIDTH-1:0]       sh_data;
    rd_entry_t                   issue_entry;
    rd_entry_t                   cmp_entry;
    logic                        cmp_fire;
    logic                        cmp_bad;
    logic                        viol_now;
    logic                        unused_addr_hi;

    assign running   = (state == RUN);
    assign sweep_en  = (state == CLEAR) && !clear_i;
    assign w_tracked = ~|(waddr_i >> TRACK_ADDR_WIDTH);
    assign r_tracked = ~|(raddr_i >> TRACK_ADDR_WIDTH);
    assign shadow_we = running && !clear_i && wen_i && w_tracked;
    assign viol_now  = (wen_i || ren_i) && !running && !clear_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            sweep_idx <= '0;
        end else if (clear_i) begin
            state     <= CLEAR;
            sweep_idx <= '0;
        end else if (state == CLEAR) begin
            if (sweep_idx == LAST_IDX) begin
                state <= RUN;
            end else begin
                sweep_idx <= sweep_idx + 1'b1;
            end
        end
    end

    servisia_scb_shadow #(
        .IDX_WIDTH  (TRACK_ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shadow (
        .clk     (clk_i),
        .wen     (shadow_we),
        .widx    (waddr_i[TRACK_ADDR_WIDTH-1:0]),
        .wdat    (wdata_i),
        .ridx    (raddr_i[TRACK_ADDR_WIDTH-1:0]),
        .rvalid  (sh_valid),
        .rdata   (sh_data),
        .clr_en  (sweep_en),
        .clr_idx (sweep_idx)
    );

    // Expected value is the shadow content before this edge, so a same-cycle write reads old data.
    always_comb begin
        issue_entry       = '0;
        issue_entry.valid = running && !clear_i && ren_i && r_tracked && sh_valid;
        issue_entry.addr  = SCB_MAX_ADDR_WIDTH'(raddr_i);
        issue_entry.exp   = SCB_MAX_DATA_WIDTH'(sh_data);
    end

    generate
        if (RD_LATENCY == 0) begin : g_nopipe
            assign cmp_entry = issue_entry;
        end else begin : g_pipe
            rd_entry_t pipe [RD_LATENCY];

            always_ff @(posedge clk_i or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < RD_LATENCY; i++) begin
                        pipe[i] <= '0;
                    end
                end else if (clear_i) begin
                    for (int i = 0; i < RD_LATENCY; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= issue_entry;
                    for (int i = 1; i < RD_LATENCY; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign cmp_entry = pipe[RD_LATENCY-1];
        end
    endgenerate

    assign cmp_fire       = cmp_entry.valid && !clear_i;
    assign cmp_bad        = cmp_fire && (cmp_entry.exp != SCB_MAX_DATA_WIDTH'(rdata_i));
    assign unused_addr_hi = ^cmp_entry.addr;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            err_o          <= 1'b0;
            viol_o         <= 1'b0;
            check_cnt_o    <= '0;
            mismatch_cnt_o <= '0;
            first_valid_o  <= 1'b0;
            first_addr_o   <= '0;
            first_exp_o    <= '0;
            first_got_o    <= '0;
        end else if (clear_i) begin
            err_o          <= 1'b0;
            viol_o         <= 1'b0;
            check_cnt_o    <= '0;
            mismatch_cnt_o <= '0;
            first_valid_o  <= 1'b0;
            first_addr_o   <= '0;
            first_exp_o    <= '0;
            first_got_o    <= '0;
        end else begin
            if (viol_now) begin
                viol_o <= 1'b1;
                err_o  <= 1'b1;
            end
            if (cmp_fire) begin
                check_cnt_o <= CNT_WIDTH'(sat_inc(SCB_MAX_CNT_WIDTH'(check_cnt_o), CNT_WIDTH));
            end
            if (cmp_bad) begin
                mismatch_cnt_o <= CNT_WIDTH'(sat_inc(SCB_MAX_CNT_WIDTH'(mismatch_cnt_o), CNT_WIDTH));
                err_o          <= 1'b1;
                if (!first_valid_o) begin
                    first_valid_o <= 1'b1;
                    first_addr_o  <= cmp_entry.addr[ADDR_WIDTH-1:0];
                    first_exp_o   <= cmp_entry.exp[DATA_WIDTH-1:0];
                    first_got_o   <= rdata_i;
                end
            end
        end
    end

    assign ready_o = running;

endmodule

// File: tb/tb_servisia_sram_scoreboard.sv
// Directed bench for servisia_sram_scoreboard at default parameters (RD_LATENCY=1).
module tb_servisia_sram_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        wen = 1'b0;
    logic [20:0] waddr = '0;
    logic [7:0]  wdata = '0;
    logic        ren = 1'b0;
    logic [20:0] raddr = '0;
    logic [7:0]  rdata = '0;
    logic        ready;
    logic        err;
    logic        viol;
    logic [15:0] check_cnt;
    logic [15:0] mismatch_cnt;
    logic        first_valid;
    logic [20:0] first_addr;
    logic [7:0]  first_exp;
    logic [7:0]  first_got;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    servisia_sram_scoreboard dut (
        .clk_i          (clk),
        .rst_n          (rst_n),
        .clear_i        (clear),
        .wen_i          (wen),
        .waddr_i        (waddr),
        .wdata_i        (wdata),
        .ren_i          (ren),
        .raddr_i        (raddr),
        .rdata_i        (rdata),
        .ready_o        (ready),
        .err_o          (err),
        .viol_o         (viol),
        .check_cnt_o    (check_cnt),
        .mismatch_cnt_o (mismatch_cnt),
        .first_valid_o  (first_valid),
        .first_addr_o   (first_addr),
        .first_exp_o    (first_exp),
        .first_got_o    (first_got)
    );

    typedef struct {
        logic        wen;
        logic [20:0] waddr;
        logic [7:0]  wdata;
        logic        ren;
        logic [20:0] raddr;
        logic [7:0]  rdata;
        int          exp_chk;
        int          exp_mis;
        logic        exp_err;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic w, input logic [20:0] wa, input logic [7:0] wd,
                                input logic r, input logic [20:0] ra, input logic [7:0] rd,
                                input int ec, input int em, input logic ee);
        vec_t v;
        v.wen = w; v.waddr = wa; v.wdata = wd;
        v.ren = r; v.raddr = ra; v.rdata = rd;
        v.exp_chk = ec; v.exp_mis = em; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 1'b0; ren = 1'b0; clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".err"}, 32'(err), 32'h0);
        chk({tag, ".viol"}, 32'(viol), 32'h0);
        chk({tag, ".check_cnt"}, 32'(check_cnt), 32'h0);
        chk({tag, ".mismatch_cnt"}, 32'(mismatch_cnt), 32'h0);
        chk({tag, ".first_valid"}, 32'(first_valid), 32'h0);
        chk({tag, ".first_addr"}, 32'(first_addr), 32'h0);
        chk({tag, ".first_exp"}, 32'(first_exp), 32'h0);
        chk({tag, ".first_got"}, 32'(first_got), 32'h0);
    endtask

    initial begin
        int n;

        // {wen, waddr, wdata, ren, raddr, rdata(returned for previous read), chk, mis, err}
        vecs[0]  = mk(1, 21'h010,  8'h41, 0, 21'h000,  8'h00, 0, 0, 0);
        vecs[1]  = mk(0, 21'h000,  8'h00, 1, 21'h010,  8'h00, 0, 0, 0);
        vecs[2]  = mk(0, 21'h000,  8'h00, 0, 21'h000,  8'h41, 1, 0, 0);
        vecs[3]  = mk(1, 21'h020,  8'h77, 0, 21'h000,  8'h00, 1, 0, 0);
        vecs[4]  = mk(0, 21'h000,  8'h00, 1, 21'h010,  8'h00, 1, 0, 0);
        vecs[5]  = mk(0, 21'h000,  8'h00, 1, 21'h020,  8'h42, 2, 1, 1);
        vecs[6]  = mk(0, 21'h000,  8'h00, 0, 21'h000,  8'h99, 3, 2, 1);
        vecs[7]  = mk(1, 21'h030,  8'h11, 0, 21'h000,  8'h00, 3, 2, 1);
        vecs[8]  = mk(1, 21'h030,  8'h55, 1, 21'h030,  8'h00, 3, 2, 1);
        vecs[9]  = mk(0, 21'h000,  8'h00, 1, 21'h030,  8'h11, 4, 2, 1);
        vecs[10] = mk(0, 21'h000,  8'h00, 1, 21'h040,  8'h55, 5, 2, 1);
        vecs[11] = mk(0, 21'h000,  8'h00, 1, 21'h1000, 8'hEE, 5, 2, 1);
        vecs[12] = mk(1, 21'h1000, 8'hAB, 0, 21'h000,  8'hEE, 5, 2, 1);
        vecs[13] = mk(0, 21'h000,  8'h00, 1, 21'h000,  8'h00, 5, 2, 1);
        vecs[14] = mk(0, 21'h000,  8'h00, 0, 21'h000,  8'hAB, 5, 2, 1);
        vecs[15] = mk(0, 21'h000,  8'h00, 1, 21'h030,  8'h00, 5, 2, 1);
        vecs[16] = mk(0, 21'h000,  8'h00, 1, 21'h020,  8'h55, 6, 2, 1);
        vecs[17] = mk(0, 21'h000,  8'h00, 0, 21'h000,  8'h77, 7, 2, 1);

        // Reset state
        #1;
        chk("rst.ready", 32'(ready), 32'h0);
        check_all_zero("rst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // ready rises on the 4096th edge after release
        n = 0;
        while (!ready && n < 5000) begin
            tick();
            n++;
        end
        chk("sweep.edges_to_ready", 32'(n), 32'd4096);
        check_all_zero("sweep");

        foreach (vecs[i]) begin
            wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            ren = vecs[i].ren; raddr = vecs[i].raddr; rdata = vecs[i].rdata;
            tick();
            chk($sformatf("vec%0d.check_cnt", i), 32'(check_cnt), 32'(vecs[i].exp_chk));
            chk($sformatf("vec%0d.mismatch_cnt", i), 32'(mismatch_cnt), 32'(vecs[i].exp_mis));
            chk($sformatf("vec%0d.err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d.viol", i), 32'(viol), 32'h0);
            chk($sformatf("vec%0d.ready", i), 32'(ready), 32'h1);
        end
        idle();

        chk("first.valid", 32'(first_valid), 32'h1);
        chk("first.addr", 32'(first_addr), 32'h010);
        chk("first.exp", 32'(first_exp), 32'h41);
        chk("first.got", 32'(first_got), 32'h42);

        // Saturation: 65536 good back-to-back reads on top of the 7 already counted
        wen = 1'b1; waddr = 21'h050; wdata = 8'h5A;
        tick();
        wen = 1'b0; ren = 1'b1; raddr = 21'h050; rdata = 8'h5A;
        for (int i = 0; i < 65536; i++) tick();
        ren = 1'b0;
        tick();
        chk("sat.check_cnt", 32'(check_cnt), 32'hFFFF);
        chk("sat.mismatch_cnt", 32'(mismatch_cnt), 32'd2);
        ren = 1'b1;
        tick();
        ren = 1'b0;
        tick();
        chk("sat.hold", 32'(check_cnt), 32'hFFFF);

        // clear_i beats an in-flight mismatching compare
        ren = 1'b1; raddr = 21'h050;
        tick();
        ren = 1'b0; rdata = 8'h00; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr.ready", 32'(ready), 32'h0);
        check_all_zero("clr");

        // Traffic during CLEAR is a violation and is ignored
        wen = 1'b1; waddr = 21'h060; wdata = 8'h12;
        tick();
        wen = 1'b0;
        chk("viol.viol", 32'(viol), 32'h1);
        chk("viol.err", 32'(err), 32'h1);
        chk("viol.ready", 32'(ready), 32'h0);
        chk("viol.check_cnt", 32'(check_cnt), 32'h0);

        n = 1;
        while (!ready && n < 5000) begin
            tick();
            n++;
        end
        chk("reclr.edges_to_ready", 32'(n), 32'd4096);
        chk("reclr.viol_sticky", 32'(viol), 32'h1);

        // Sweep invalidated the shadow: old addresses and the violating write are not compared
        ren = 1'b1; raddr = 21'h050;
        tick();
        raddr = 21'h060; rdata = 8'h00;
        tick();
        ren = 1'b0;
        tick();
        chk("reclr.check_cnt", 32'(check_cnt), 32'h0);
        chk("reclr.mismatch_cnt", 32'(mismatch_cnt), 32'h0);

        // Asynchronous reset mid-cycle clears state at once
        #2 rst_n = 1'b0;
        #1;
        chk("arst.ready", 32'(ready), 32'h0);
        chk("arst.viol", 32'(viol), 32'h0);
        chk("arst.err", 32'(err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
